rx_word_fifo: RTL
=================

Name: rx_word_fifo

Overview:
- Buffers 16-bit status/data words from rx_top (rx_spi_data/rx_strobe/rx_accept) until the SPI host interface reads them.
- Decouples the Econet line-rate receive path from slow SPI polling.
- Provides a fill level, a level-threshold interrupt and a sticky backpressure flag.
- Sits directly downstream of rx_top, in the mclk domain.

Parameters:
- DEPTH, 64, number of 16-bit words stored; power of two, minimum 4.
- AW, 6, pointer width; must equal log2(DEPTH).
- THRESH, 48, fill level at or above which irq_level asserts; range 1..DEPTH.

Ports:
- clk  in  1  single clock, same clock as the rx_top SPI side (mclk).
- reset  in  1  asynchronous, active-low reset.
- rx_spi_data  in  16  word from rx_top; valid while rx_strobe is high.
- rx_strobe  in  1  rx_top has a word pending; held until accepted.
- rx_accept  out  1  FIFO takes the word this cycle.
- rd_data  out  16  head word; valid when rd_valid is high.
- rd_valid  out  1  head word is present (first-word-fall-through).
- rd_en  in  1  host pops the head word; ignored when rd_valid is low.
- flush  in  1  synchronous discard of all contents.
- clr_stall  in  1  clears stall_seen.
- level  out  AW+1  number of words held, 0..DEPTH; rd_data is included.
- irq_level  out  1  level >= THRESH.
- stall_seen  out  1  sticky flag: rx_strobe was high while rx_accept was low.

Behaviour:
- Reset (reset low, asynchronous) forces all pointers and level to 0 and drives rd_valid, stall_seen and irq_level to 0. rx_accept is 1 one cycle after reset is released. rd_data is a don't-care while rd_valid is low.
- Write: a word is accepted on a rising clk edge where rx_strobe and rx_accept are both high.
- Write data path: rx_spi_data is stored at wr_ptr and wr_ptr increments modulo DEPTH.
- rx_accept is registered and equals (level_next < DEPTH). It is combinationally independent of rx_strobe and rd_en.
- Full with simultaneous pop: when full, rx_accept is 0 even if rd_en pops in the same cycle. rx_accept reasserts on the following cycle.
- Read: FWFT with a registered output stage.
  - A word written into an empty FIFO at edge N appears on rd_data/rd_valid after edge N+1, so write-to-visible latency is 2 edges.
  - A pop at an edge presents the next word on rd_data immediately after that edge if one is stored. Otherwise rd_valid falls.
- Level counting:
  - Write only: level +1.
  - Pop only: level -1.
  - Simultaneous write and pop: level unchanged.
  - level counts words in memory plus the output stage, so the maximum is DEPTH.
- Empty FIFO: rd_en with rd_valid low has no effect; pointers and level are unchanged.
- Wrap-around: pointers are AW bits and wrap silently. Full/empty are derived from level, not from a pointer compare.
- flush:
  - At the edge where flush is high, pointers go to 0, level goes to 0 and rd_valid goes to 0.
  - flush overrides a write and a pop in the same cycle; a word presented with rx_strobe that cycle is not accepted.
  - rx_accept is 0 during a flush cycle.
- stall_seen:
  - Set at any edge where rx_strobe is 1 and rx_accept is 0.
  - Cleared by clr_stall.
  - If set and clear occur in the same cycle, set wins.
- irq_level is registered from level_next, so it changes at the same edge as level.
- No data checking: word contents (status byte / data byte) pass through untouched.

Decomposition:
- Shared package holds:
  - constant RX_WORD_W = 16, reused by rx_top and the SPI block;
  - the rx word field offsets (status byte [15:8], data byte [7:0]).
- One sub-module, fifo_ram_1r1w: DEPTH x 16 simple dual-port memory with a synchronous read, so it infers block RAM.
- Pointers, level, the output stage and the flags stay in rx_word_fifo.

Test Plan:
- Reset and single word:
  - Stimulus: release reset; present rx_spi_data=16'h0153 with rx_strobe.
  - Response: rx_accept=1; level=1 one edge later; rd_valid=1 with rd_data=16'h0153 two edges after the accept.
  - Then rd_en for one cycle gives rd_valid=0 and level=0.
- Fill to full:
  - Stimulus: write 64 words 16'h0000..16'h003F with no reads.
  - Response: irq_level rises at the edge where level reaches 48; level reaches 64; rx_accept drops to 0.
  - Then hold rx_strobe for 3 more cycles: stall_seen=1 and level stays 64.
- Drain with wrap:
  - Stimulus: from full, pop 10 words, write 10 words 16'h0100..16'h0109, then drain all.
  - Response: words read out in order 16'h000A..16'h003F, then 16'h0100..16'h0109; pointers wrap with no duplication or loss.
- Simultaneous write and pop at mid level:
  - Stimulus: level=5; assert rx_strobe and rd_en together for 4 cycles.
  - Response: level stays 5 throughout; output order is preserved.
- Flush and clr_stall collision:
  - Stimulus: level=20; assert flush together with rx_strobe and rd_en.
  - Response: level=0, rd_valid=0, and the word is not stored.
  - Then with stall_seen=1, assert clr_stall in the same cycle as a new stall event: stall_seen remains 1.
- Asynchronous reset mid-operation:
  - Stimulus: assert reset between clock edges with level=30.
  - Response: level=0, rd_valid=0, irq_level=0 and stall_seen=0 immediately, without waiting for a clk edge.

Source files
------------

// File: rtl/rx_word_fifo_pkg.sv
// Shared definitions for the Econet receive word path (rx_top, rx_word_fifo, SPI host block).
package rx_word_fifo_pkg;

    // Width of one receive word as passed from rx_top to the SPI host interface.
    localparam int RX_WORD_W = 16;

    // Field layout of a receive word: status byte on top, data byte below.
    localparam int RX_STATUS_MSB = 15;
    localparam int RX_STATUS_LSB = 8;
    localparam int RX_DATA_MSB   = 7;
    localparam int RX_DATA_LSB   = 0;

    typedef struct packed {
        logic [RX_STATUS_MSB-RX_STATUS_LSB:0] status;
        logic [RX_DATA_MSB-RX_DATA_LSB:0]     data;
    } rx_word_t;

endpackage

// File: rtl/rx_word_fifo_if.sv
// Handshake bundle between rx_top (writer), rx_word_fifo and the SPI host (reader).
// master = the surrounding logic driving the FIFO, slave = the FIFO itself.
interface rx_word_fifo_if #(
    parameter int AW = 6
);
    import rx_word_fifo_pkg::*;

    logic [RX_WORD_W-1:0] rx_spi_data;
    logic                 rx_strobe;
    logic                 rx_accept;
    logic [RX_WORD_W-1:0] rd_data;
    logic                 rd_valid;
    logic                 rd_en;
    logic                 flush;
    logic                 clr_stall;
    logic [AW:0]          level;
    logic                 irq_level;
    logic                 stall_seen;

    modport master (
        output rx_spi_data, rx_strobe, rd_en, flush, clr_stall,
        input  rx_accept, rd_data, rd_valid, level, irq_level, stall_seen
    );

    modport slave (
        input  rx_spi_data, rx_strobe, rd_en, flush, clr_stall,
        output rx_accept, rd_data, rd_valid, level, irq_level, stall_seen
    );

endinterface

// File: rtl/rx_word_fifo_ram.sv
// Simple dual-port word memory with a synchronous read port, shaped so it maps onto block RAM.
// The registered read data doubles as the FIFO's output stage.
module fifo_ram_1r1w
    import rx_word_fifo_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int AW    = 6
) (
    input  logic                 clk_i,
    input  logic                 we_i,
    input  logic [AW-1:0]        waddr_i,
    input  logic [RX_WORD_W-1:0] wdata_i,
    input  logic                 re_i,
    input  logic [AW-1:0]        raddr_i,
    output logic [RX_WORD_W-1:0] rdata_o
);

    logic [RX_WORD_W-1:0] mem_q [DEPTH];
    logic [RX_WORD_W-1:0] rdata_q;

    // Write port and registered read port; no reset so the array stays a RAM.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/rx_word_fifo.sv
// First-word-fall-through buffer for receive words between rx_top and the SPI host.
// level counts words in the RAM plus the one held in the output stage; full/empty come
// from level, so the AW-bit pointers are free to wrap.
module rx_word_fifo
    import rx_word_fifo_pkg::*;
#(
    parameter int DEPTH  = 64,
    parameter int AW     = 6,
    parameter int THRESH = 48
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    rx_word_fifo_if.slave  bus
);

    localparam logic [AW:0]   FULL_LVL   = {1'b1, {AW{1'b0}}};
    localparam logic [AW:0]   THRESH_LVL = THRESH[AW:0];
    localparam logic [AW:0]   LVL_ONE    = {{AW{1'b0}}, 1'b1};
    localparam logic [AW-1:0] PTR_ONE    = {{(AW-1){1'b0}}, 1'b1};

    logic [AW-1:0]        wrPtr_q, wrPtr_d;
    logic [AW-1:0]        rdPtr_q, rdPtr_d;
    logic [AW:0]          level_q, level_d;
    logic                 rdValid_q, rdValid_d;
    logic                 accept_q;
    logic                 irq_q;
    logic                 stall_q;

    logic                 rxAccept;
    logic                 wrEn;
    logic                 popEn;
    logic                 memEmpty;
    logic                 loadOut;
    logic [RX_WORD_W-1:0] ramRdata;

    fifo_ram_1r1w #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk_i   (clk_i),
        .we_i    (wrEn),
        .waddr_i (wrPtr_q),
        .wdata_i (bus.rx_spi_data),
        .re_i    (loadOut),
        .raddr_i (rdPtr_q),
        .rdata_o (ramRdata)
    );

    // Next-state: flush wins over everything; otherwise the output stage refills from RAM
    // whenever it is empty or being popped and the RAM holds an older word.
    always_comb begin
        rxAccept  = accept_q && !bus.flush;
        wrEn      = bus.rx_strobe && rxAccept;
        popEn     = bus.rd_en && rdValid_q && !bus.flush;
        memEmpty  = (level_q == {{AW{1'b0}}, rdValid_q});
        loadOut   = (!rdValid_q || popEn) && !memEmpty && !bus.flush;
        wrPtr_d   = wrPtr_q;
        rdPtr_d   = rdPtr_q;
        level_d   = level_q;
        rdValid_d = rdValid_q;
        if (bus.flush) begin
            wrPtr_d   = '0;
            rdPtr_d   = '0;
            level_d   = '0;
            rdValid_d = 1'b0;
        end else begin
            if (wrEn) begin
                wrPtr_d = wrPtr_q + PTR_ONE;
            end
            if (loadOut) begin
                rdPtr_d   = rdPtr_q + PTR_ONE;
                rdValid_d = 1'b1;
            end else if (popEn) begin
                rdValid_d = 1'b0;
            end
            case ({wrEn, popEn})
                2'b10:   level_d = level_q + LVL_ONE;
                2'b01:   level_d = level_q - LVL_ONE;
                default: level_d = level_q;
            endcase
        end
    end

    // State and flag registers; accept and irq look at level_d so they move with level.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wrPtr_q   <= '0;
            rdPtr_q   <= '0;
            level_q   <= '0;
            rdValid_q <= 1'b0;
            accept_q  <= 1'b0;
            irq_q     <= 1'b0;
            stall_q   <= 1'b0;
        end else begin
            wrPtr_q   <= wrPtr_d;
            rdPtr_q   <= rdPtr_d;
            level_q   <= level_d;
            rdValid_q <= rdValid_d;
            accept_q  <= (level_d < FULL_LVL);
            irq_q     <= (level_d >= THRESH_LVL);
            if (bus.rx_strobe && !rxAccept) begin
                stall_q <= 1'b1;
            end else if (bus.clr_stall) begin
                stall_q <= 1'b0;
            end
        end
    end

    assign bus.rx_accept  = rxAccept;
    assign bus.rd_data    = ramRdata;
    assign bus.rd_valid   = rdValid_q;
    assign bus.level      = level_q;
    assign bus.irq_level  = irq_q;
    assign bus.stall_seen = stall_q;

endmodule
